// File: rtl/date_pkg.sv
// Shared calendar definitions: FSM states, digit count, month lengths.
// Used by the date streamer and the calendar counter.
package date_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    CONV,
    SEND
  } state_t;

  localparam int NUM_DIGITS = 6;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  localparam logic [4:0] FEB = 5'd2;
  localparam logic [4:0] APR = 5'd4;
  localparam logic [4:0] JUN = 5'd6;
  localparam logic [4:0] SEP = 5'd9;
  localparam logic [4:0] NOV = 5'd11;
  localparam logic [4:0] DEC = 5'd12;

  localparam logic [6:0] YEAR_MAX = 7'd99;

  function automatic logic [4:0] days_in_month(
    input logic [4:0] month,
    input logic [6:0] year,
    input logic       leap_en
  );
    logic [4:0] d;
    d = 5'd31;
    if (month == APR || month == JUN ||
        month == SEP || month == NOV)
      d = 5'd30;
    else if (month == FEB)
      d = (leap_en && year[1:0] == 2'b00)
          ? 5'd29 : 5'd28;
    return d;
  endfunction

endpackage

// File: rtl/date_digit_streamer_div10.sv
// Iterative divide-by-10: one subtract of 10 per cycle after start.
// done looks one step ahead so the final subtract overlaps the exit.
module div10_iter (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] value,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       done
);

  logic [6:0] rem;
  logic [3:0] quo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem <= 7'd0;
      quo <= 4'd0;
    end else if (start) begin
      rem <= value;
      quo <= 4'd0;
    end else if (rem >= 7'd10) begin
      rem <= rem - 7'd10;
      quo <= quo + 4'd1;
    end
  end

  assign done  = (rem < 7'd20);
  assign tens  = quo;
  assign units = rem[3:0];

endmodule

// File: rtl/date_digit_streamer.sv
// Captures a binary date, validates it, converts to BCD
// and streams six digits over a valid/ready handshake.
module date_digit_streamer
  import date_pkg::*;
#(
  parameter bit LEAP_EN = 1'b0,
  parameter bit FMT     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] year,
  input  logic [4:0] month,
  input  logic [4:0] day,
  input  logic       date_valid,
  output logic       in_ready,
  output logic [3:0] digit,
  output logic [2:0] digit_idx,
  output logic       digit_valid,
  output logic       digit_last,
  input  logic       out_ready,
  output logic       date_err
);

  state_t state_q, state_d;

  logic [6:0] y_q;
  logic [4:0] m_q;
  logic [4:0] d_q;
  logic [2:0] idx_q;

  logic illegal;
  logic start;
  logic accept;
  logic last_beat;
  logic all_done;

  logic [3:0] yt, yu, mt, mu, dt, du;
  logic       y_done, m_done, d_done;
  logic [23:0] frame;
  logic [3:0]  pick;

  assign illegal = (y_q > YEAR_MAX) ||
                   (m_q == 5'd0) || (m_q > DEC) ||
                   (d_q == 5'd0) ||
                   (d_q > days_in_month(m_q, y_q, LEAP_EN));

  assign start     = (state_q == CHECK) && !illegal;
  assign all_done  = y_done && m_done && d_done;
  assign accept    = digit_valid && out_ready;
  assign last_beat = (idx_q == LAST_IDX);

  div10_iter u_div_y (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (y_q),
    .tens  (yt),
    .units (yu),
    .done  (y_done)
  );

  div10_iter u_div_m (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value ({2'b00, m_q}),
    .tens  (mt),
    .units (mu),
    .done  (m_done)
  );

  div10_iter u_div_d (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value ({2'b00, d_q}),
    .tens  (dt),
    .units (du),
    .done  (d_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q <= 7'd0;
      m_q <= 5'd0;
      d_q <= 5'd0;
    end else if (state_q == IDLE && date_valid) begin
      y_q <= year;
      m_q <= month;
      d_q <= day;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= 3'd0;
    end else if (accept) begin
      idx_q <= last_beat ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (date_valid) state_d = CHECK;
      CHECK: state_d = illegal ? IDLE : CONV;
      CONV:  if (all_done) state_d = SEND;
      SEND:  if (accept && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame is laid out tens-before-units, first digit in the top nibble.
  assign frame = FMT ? {yt, yu, mt, mu, dt, du}
                     : {dt, du, mt, mu, yt, yu};

  always_comb begin
    pick = 4'd0;
    case (idx_q)
      3'd0: pick = frame[23:20];
      3'd1: pick = frame[19:16];
      3'd2: pick = frame[15:12];
      3'd3: pick = frame[11:8];
      3'd4: pick = frame[7:4];
      3'd5: pick = frame[3:0];
      default: pick = 4'd0;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign digit_valid = (state_q == SEND);
  assign digit_last  = digit_valid && last_beat;
  assign digit       = digit_valid ? pick : 4'd0;
  assign digit_idx   = idx_q;
  assign date_err    = (state_q == CHECK) && illegal;

endmodule
